// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the hazard/forwarding controller
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_EX  = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      IDLE    = 1'b0,
      MC_BUSY = 1'b1
   } hz_state_e;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - single-operand bypass select, EX/MEM wins over MEM/WB
module fwd_select
   import hazard_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] exmem_rd,
   input  logic          exmem_regwrite,
   input  logic [AW-1:0] memwb_rd,
   input  logic          memwb_regwrite,
   output logic [1:0]    sel
);

   fwd_sel_e sel_e;

   // Register 0 is hardwired, so a write to it never produces a bypass.
   always_comb begin
      sel_e = FWD_RF;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src))
         sel_e = FWD_EX;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src))
         sel_e = FWD_MEM;
   end

   assign sel = sel_e;

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - forwarding, load-use bubble and multi-cycle freeze; HAZARD_PERF_CNT_EN enables stall_cycles
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int AW         = 5,
   parameter int NUM_SRC    = 2,
   parameter int MC_LATENCY = 4,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_SRC*AW-1:0] ifid_src,
   input  logic [NUM_SRC*AW-1:0] idex_src,
   input  logic [AW-1:0]         idex_rd,
   input  logic                  idex_memread,
   input  logic                  idex_mc_start,
   input  logic [AW-1:0]         exmem_rd,
   input  logic                  exmem_regwrite,
   input  logic [AW-1:0]         memwb_rd,
   input  logic                  memwb_regwrite,
   output logic [2*NUM_SRC-1:0]  forward,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  idex_write,
   output logic                  idex_flush,
   output logic                  exmem_flush,
   output logic                  mc_busy,
   output logic [CNT_W-1:0]      stall_cycles
);

   localparam int CW = $clog2(MC_LATENCY + 1);

   hz_state_e     state;
   logic [CW-1:0] cnt;
   logic          mc_freeze;
   logic          lu_match;
   logic          load_use;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
      logic [1:0] sel;

      fwd_select #(.AW(AW)) u_fwd_select (
         .src            (idex_src[i*AW +: AW]),
         .exmem_rd       (exmem_rd),
         .exmem_regwrite (exmem_regwrite),
         .memwb_rd       (memwb_rd),
         .memwb_regwrite (memwb_regwrite),
         .sel            (sel)
      );

      assign forward[2*i +: 2] = rst ? 2'b00 : sel;
   end

   always_comb begin
      lu_match = 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
         if (ifid_src[i*AW +: AW] == idex_rd)
            lu_match = 1'b1;
   end

   // The multi-cycle freeze masks load-use; the bubble waits until the FSM is idle again.
   assign mc_freeze = !rst && ((state == MC_BUSY) || idex_mc_start);
   assign load_use  = !rst && !mc_freeze && idex_memread && (idex_rd != '0) && lu_match;

   assign pc_write    = !(mc_freeze || load_use);
   assign ifid_write  = !(mc_freeze || load_use);
   assign idex_write  = !mc_freeze;
   assign idex_flush  = load_use;
   assign exmem_flush = mc_freeze;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         mc_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (idex_mc_start && (MC_LATENCY > 1)) begin
                  state   <= MC_BUSY;
                  cnt     <= CW'(MC_LATENCY - 1);
                  mc_busy <= 1'b1;
               end
            end
            MC_BUSY: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state   <= IDLE;
                  mc_busy <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               mc_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (!pc_write && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign stall_cycles = stall_cnt;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  ifid_src;
   logic [9:0]  idex_src;
   logic [4:0]  idex_rd;
   logic        idex_memread;
   logic        idex_mc_start;
   logic [4:0]  exmem_rd;
   logic        exmem_regwrite;
   logic [4:0]  memwb_rd;
   logic        memwb_regwrite;

   logic [3:0]  fwd [2];
   logic [1:0]  pc_w, ifid_w, idex_w, idex_fl, exmem_fl, busy;
   logic [3:0]  stall_a;
   logic [31:0] stall_b;

   int n_checks = 0;
   int n_fails  = 0;

   int     lat  [2] = '{4, 1};
   longint smax [2] = '{15, 64'hFFFF_FFFF};
   longint fl   [2] = '{0, 0};
   longint st   [2] = '{0, 0};

   logic [3:0] snap_fwd;
   logic       snap_pc, snap_ifid, snap_idexfl, snap_exfl;

   always #5 clk = ~clk;

   hazard_forward_unit #(.AW(5), .NUM_SRC(2), .MC_LATENCY(4), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .ifid_src(ifid_src), .idex_src(idex_src), .idex_rd(idex_rd),
      .idex_memread(idex_memread), .idex_mc_start(idex_mc_start),
      .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
      .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
      .forward(fwd[0]), .pc_write(pc_w[0]), .ifid_write(ifid_w[0]), .idex_write(idex_w[0]),
      .idex_flush(idex_fl[0]), .exmem_flush(exmem_fl[0]), .mc_busy(busy[0]),
      .stall_cycles(stall_a)
   );

   hazard_forward_unit #(.AW(5), .NUM_SRC(2), .MC_LATENCY(1), .CNT_W(32)) dut_b (
      .clk(clk), .rst(rst), .ifid_src(ifid_src), .idex_src(idex_src), .idex_rd(idex_rd),
      .idex_memread(idex_memread), .idex_mc_start(idex_mc_start),
      .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
      .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
      .forward(fwd[1]), .pc_write(pc_w[1]), .ifid_write(ifid_w[1]), .idex_write(idex_w[1]),
      .idex_flush(idex_fl[1]), .exmem_flush(exmem_fl[1]), .mc_busy(busy[1]),
      .stall_cycles(stall_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] s);
      if (rst) return 2'b00;
      if (exmem_regwrite && exmem_rd != 0 && exmem_rd == s) return 2'b10;
      if (memwb_regwrite && memwb_rd != 0 && memwb_rd == s) return 2'b01;
      return 2'b00;
   endfunction

   function automatic longint exp_stall(input int k);
`ifdef HAZARD_PERF_CNT_EN
      return st[k];
`else
      return 0;
`endif
   endfunction

   // One pipeline cycle: check combinational outputs, clock, then check registered outputs.
   task automatic run_cycle();
      logic frozen, lu, pcw;
      logic [8:0] exp_v, obs_v;
      logic [0:1] pcw_k;
      logic [63:0] obs_st;
      #1;
      for (int k = 0; k < 2; k++) begin
         frozen = !rst && (fl[k] > 0 || idex_mc_start);
         lu = !rst && !frozen && idex_memread && idex_rd != 0 &&
              (idex_rd == ifid_src[4:0] || idex_rd == ifid_src[9:5]);
         pcw = !(frozen || lu);
         pcw_k[k] = pcw;
         exp_v = {ref_fwd(idex_src[9:5]), ref_fwd(idex_src[4:0]), pcw, pcw, !frozen, lu, frozen};
         obs_v = {fwd[k], pc_w[k], ifid_w[k], idex_w[k], idex_fl[k], exmem_fl[k]};
         check(k == 0 ? "comb_a" : "comb_b", 64'(obs_v), 64'(exp_v));
      end
      snap_fwd = fwd[0]; snap_pc = pc_w[0]; snap_ifid = ifid_w[0];
      snap_idexfl = idex_fl[0]; snap_exfl = exmem_fl[0];
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            fl[k] = 0;
            st[k] = 0;
         end else begin
            if (fl[k] > 0) fl[k] = fl[k] - 1;
            else if (idex_mc_start) fl[k] = lat[k] - 1;
            if (!pcw_k[k] && st[k] < smax[k]) st[k] = st[k] + 1;
         end
         obs_st = (k == 0) ? 64'(stall_a) : 64'(stall_b);
         check(k == 0 ? "busy_a" : "busy_b", 64'(busy[k]), 64'(fl[k] > 0));
         check(k == 0 ? "stall_a" : "stall_b", obs_st, 64'(exp_stall(k)));
      end
   endtask

   initial begin
      rst = 1'b1; ifid_src = '0; idex_src = '0; idex_rd = '0; idex_memread = 1'b0;
      idex_mc_start = 1'b0; exmem_rd = '0; exmem_regwrite = 1'b0; memwb_rd = '0;
      memwb_regwrite = 1'b0;
      @(posedge clk); #1;
      run_cycle();
      run_cycle();
      check("reset_busy", 64'(busy[0]), 64'd0);
      check("reset_stall", 64'(stall_a), 64'd0);
      rst = 1'b0;

      exmem_rd = 5'd3; memwb_rd = 5'd3; exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
      idex_src = {5'd0, 5'd3};
      run_cycle();
      check("fwd_ex_prio", 64'(snap_fwd[1:0]), 64'b10);
      exmem_regwrite = 1'b0;
      run_cycle();
      check("fwd_mem", 64'(snap_fwd[1:0]), 64'b01);
      exmem_rd = 5'd0; exmem_regwrite = 1'b1; memwb_regwrite = 1'b0; idex_src = {5'd0, 5'd7};
      run_cycle();
      check("fwd_r0", 64'(snap_fwd[3:2]), 64'b00);

      idex_memread = 1'b1; idex_rd = 5'd5; ifid_src = {5'd5, 5'd1};
      run_cycle();
      check("lu_pc", 64'({snap_pc, snap_ifid, snap_idexfl}), 64'b001);
`ifdef HAZARD_PERF_CNT_EN
      check("lu_stall", 64'(stall_b), 64'd1);
`else
      check("lu_stall", 64'(stall_b), 64'd0);
`endif
      idex_memread = 1'b0;
      run_cycle();

      idex_mc_start = 1'b1; idex_memread = 1'b1;
      run_cycle();
      check("mc_start_frz", 64'({snap_pc, snap_exfl, snap_idexfl}), 64'b010);
      check("mc_busy_rise", 64'(busy[0]), 64'd1);
      idex_mc_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         check("mc_hold", 64'({snap_pc, snap_exfl, snap_idexfl}), 64'b010);
      end
      check("mc_busy_fall", 64'(busy[0]), 64'd0);
      run_cycle();
      check("lu_after_mc", 64'({snap_pc, snap_exfl, snap_idexfl}), 64'b001);
      idex_memread = 1'b0;
      run_cycle();

      idex_mc_start = 1'b1;
      run_cycle();
      idex_mc_start = 1'b0;
      run_cycle();
      rst = 1'b1;
      run_cycle();
      check("rst_mid_pc", 64'(snap_pc), 64'd1);
      check("rst_mid_busy", 64'(busy[0]), 64'd0);
      check("rst_mid_stall", 64'(stall_a), 64'd0);
      rst = 1'b0;

      idex_mc_start = 1'b1;
      for (int i = 0; i < 9; i++) begin
         run_cycle();
         check("b2b_pc", 64'(snap_pc), 64'd0);
      end
      idex_mc_start = 1'b0;
      for (int i = 0; i < 4; i++) run_cycle();

      rst = 1'b1;
      run_cycle();
      rst = 1'b0;
      idex_mc_start = 1'b1;
      for (int i = 0; i < 20; i++) run_cycle();
`ifdef HAZARD_PERF_CNT_EN
      check("stall_sat", 64'(stall_a), 64'd15);
`else
      check("stall_sat", 64'(stall_a), 64'd0);
`endif
      idex_mc_start = 1'b0;
      for (int i = 0; i < 4; i++) run_cycle();

      for (int i = 0; i < 400; i++) begin
         rst            = ($urandom_range(0, 49) == 0);
         ifid_src       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         idex_src       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         idex_rd        = 5'($urandom_range(0, 3));
         idex_memread   = ($urandom_range(0, 3) == 0);
         idex_mc_start  = ($urandom_range(0, 9) == 0);
         exmem_rd       = 5'($urandom_range(0, 3));
         exmem_regwrite = 1'($urandom_range(0, 1));
         memwb_rd       = 5'($urandom_range(0, 3));
         memwb_regwrite = 1'($urandom_range(0, 1));
         run_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard and forwarding controller for the five-stage pipeline. It handles N source operands at configurable register-address width. For each ID/EX source it generates the bypass select, with EX/MEM taking priority over MEM/WB. It detects load-use hazards and inserts a one-cycle bubble, and it freezes the pipeline for the full latency of a multi-cycle (multiply/divide) EX operation using an internal state machine and counter. It sits beside the ID and EX stages and drives the PC, IF/ID, ID/EX and EX/MEM write/flush controls.

## Interface
Parameters:
- AW, 5: register address width
- NUM_SRC, 2: number of source operands per instruction (≥1)
- MC_LATENCY, 4: cycles a multi-cycle EX op occupies EX (≥1)
- CNT_W, 32: stall performance-counter width

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ifid_src  in  NUM_SRC*AW  source register addresses of the instruction in ID; operand i at [i*AW +: AW]
- idex_src  in  NUM_SRC*AW  source register addresses of the instruction in EX
- idex_rd  in  AW  destination of the instruction in EX
- idex_memread  in  1  instruction in EX is a load
- idex_mc_start  in  1  instruction in EX is a multi-cycle op entering EX this cycle
- exmem_rd / exmem_regwrite  in  AW / 1  EX/MEM destination and write enable
- memwb_rd / memwb_regwrite  in  AW / 1  MEM/WB destination and write enable
- forward  out  2*NUM_SRC  per-operand bypass select; 00 = regfile, 10 = EX/MEM, 01 = MEM/WB
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- idex_write  out  1  ID/EX register enable
- idex_flush  out  1  insert a bubble into ID/EX
- exmem_flush  out  1  insert a bubble into EX/MEM
- mc_busy  out  1  state is MC_BUSY
- stall_cycles  out  CNT_W  count of cycles with pc_write = 0

## Operation
- Forwarding, per operand i, combinational:
  - 10 if exmem_regwrite, exmem_rd ≠ 0 and exmem_rd == idex_src[i].
  - Otherwise 01 if memwb_regwrite, memwb_rd ≠ 0 and memwb_rd == idex_src[i].
  - Otherwise 00.
  - Each write enable gates only its own stage.
- Load-use: idex_memread, idex_rd ≠ 0, and idex_rd equals any ifid_src[i]. Response: pc_write = 0, ifid_write = 0, idex_flush = 1, for exactly one cycle. The FSM stays in IDLE.
- FSM states: IDLE, MC_BUSY.
  - IDLE with idex_mc_start:
    - pc_write, ifid_write and idex_write are 0; exmem_flush is 1.
    - If MC_LATENCY > 1, the next state is MC_BUSY and cnt is loaded with MC_LATENCY−1. Otherwise the FSM stays in IDLE.
  - MC_BUSY:
    - The same freeze outputs are driven.
    - cnt decrements each cycle.
    - When cnt == 1, the next state is IDLE.
    - idex_mc_start is ignored.
- Priority: multi-cycle freeze over load-use. Load-use is not evaluated while idex_mc_start is high or in MC_BUSY; the load-use bubble applies only once the FSM is back in IDLE.
- forward stays live during a freeze, so the held EX op keeps correct operands.
- cnt width: $clog2(MC_LATENCY+1).
- Perf counter:
  - Increments on each clock where pc_write = 0 and rst = 0.
  - Saturates at all-ones.
- Defaults with no hazard: pc_write, ifid_write and idex_write are 1; both flushes are 0.

## Timing
- forward, pc_write, ifid_write, idex_write, idex_flush and exmem_flush are combinational from the inputs and the current state, in the same cycle.
- mc_busy and stall_cycles are registered.
- Multi-cycle op seen at cycle N: stall holds for cycles N through N+MC_LATENCY−1, which is MC_LATENCY cycles total. pc_write returns to 1 at cycle N+MC_LATENCY.
- Reset values: state = IDLE, cnt = 0, mc_busy = 0, stall_cycles = 0.
- While rst is high:
  - forward = 0, all writes = 1, flushes = 0.
  - No stall is counted.
- Reset asserted mid-MC_BUSY: stalls drop in that same cycle, and the FSM is in IDLE on the next edge.
- Back-to-back multi-cycle ops: a second idex_mc_start in the first IDLE cycle after MC_BUSY starts a new freeze with no gap.

## Configuration
- HAZARD_PERF_CNT_EN
  - Defined: the stall_cycles counter is implemented as described.
  - Undefined: no counter flops exist; stall_cycles is tied to 0.
  - All other behaviour is identical in both builds.

## Structure
- Package hazard_pkg holds:
  - fwd_sel_e: FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_EX = 2'b10
  - hz_state_e: IDLE, MC_BUSY
- Sub-module fwd_select: the single-operand priority comparator. It is instantiated NUM_SRC times in a generate loop.

## Test plan
- exmem_rd = memwb_rd = 3, both regwrites = 1, idex_src[0] = 3 → forward[1:0] = 10. With exmem_regwrite = 0 instead → 01.
- exmem_rd = 0 with regwrite = 1 and idex_src[1] = 0 → forward[3:2] = 00.
- idex_memread = 1, idex_rd = 5, ifid_src[1] = 5 → one cycle of pc_write = 0, ifid_write = 0, idex_flush = 1; stall_cycles +1.
- MC_LATENCY = 4, idex_mc_start pulse at cycle 10 → pc_write = 0 on cycles 10–13, mc_busy = 1 on cycles 11–13, pc_write = 1 at cycle 14. A load-use condition held throughout is honoured only at cycle 14.
- rst asserted at the second MC_BUSY cycle → stalls drop that cycle; next cycle state = IDLE and stall_cycles = 0.
- With HAZARD_PERF_CNT_EN, CNT_W = 4, and 20 consecutive stall cycles → stall_cycles saturates at 15. Without the macro it reads 0.
